// File: rtl/dsp_pkg.sv
// Shared widths, types and saturating-add helper for the dual-channel accumulator.
package dsp_pkg;

  localparam int unsigned DEFAULT_IN_W  = 16;
  localparam int unsigned DEFAULT_ACC_W = 24;
  localparam int unsigned SAT_W         = 64;

  typedef logic signed [DEFAULT_ACC_W-1:0] acc_t;
  typedef logic signed [SAT_W-1:0]         wide_t;

  typedef struct packed {
    logic  ovf;
    wide_t sum;
  } sat_t;

  typedef enum logic {
    ACCUM,
    FILL
  } state_e;

  // Add in a wide domain, then clamp to a signed w-bit range.
  function automatic sat_t sat_add(input wide_t acc, input wide_t sext_in,
                                   input int unsigned w);
    sat_t  res;
    wide_t sum;
    wide_t hi;
    wide_t lo;
    sum = acc + sext_in;
    hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo  = -hi - wide_t'(1);
    res.ovf = 1'b0;
    res.sum = sum;
    if (sum > hi) begin
      res.sum = hi;
      res.ovf = 1'b1;
    end else if (sum < lo) begin
      res.sum = lo;
      res.ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dsp_sat_acc.sv
// One channel: saturating accumulator with a sticky overflow flag.
module dsp_sat_acc
  import dsp_pkg::*;
#(
  parameter int unsigned IN_W  = DEFAULT_IN_W,
  parameter int unsigned ACC_W = DEFAULT_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic signed [IN_W-1:0]  add,
  output logic signed [ACC_W-1:0] acc_nxt_c,
  output logic                    ovf_nxt_c
);

  logic signed [ACC_W-1:0] acc_q;
  logic                    ovf_q;
  sat_t                    res;

  // Value the accumulator takes if this beat is accepted.
  always_comb begin
    res       = sat_add(wide_t'(acc_q), wide_t'(add), ACC_W);
    acc_nxt_c = ACC_W'(res.sum);
    ovf_nxt_c = ovf_q | res.ovf;
    if (load) begin
      acc_nxt_c = ACC_W'(add);
      ovf_nxt_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      acc_q <= acc_nxt_c;
      ovf_q <= ovf_nxt_c;
    end
  end

endmodule

// File: rtl/dsp_dual_acc.sv
// Accumulates LEN paired products per channel and presents the sums on a valid/ready port.
module dsp_dual_acc
  import dsp_pkg::*;
#(
  parameter int unsigned IN_W  = DEFAULT_IN_W,
  parameter int unsigned ACC_W = DEFAULT_ACC_W,
  parameter int unsigned LEN   = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic signed [IN_W-1:0]  ac_in,
  input  logic signed [IN_W-1:0]  bc_in,
  output logic signed [ACC_W-1:0] sum_ac,
  output logic signed [ACC_W-1:0] sum_bc,
  output logic                    ovf_ac,
  output logic                    ovf_bc,
  output logic                    valid_out,
  input  logic                    ready_out
);

  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last;
  logic                    accept;
  logic                    load;
  logic signed [ACC_W-1:0] nxt_ac, nxt_bc;
  logic                    nov_ac, nov_bc;

  // Only the completing beat can stall, and only when the held result is not draining.
  assign last     = (cnt_q == LAST);
  assign ready_in = !(last && valid_out && !ready_out);
  assign accept   = valid_in && ready_in && !clr;
  assign load     = (state_q == ACCUM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ACCUM;
      cnt_d   = '0;
    end else if (accept) begin
      if (last) begin
        state_d = ACCUM;
        cnt_d   = '0;
      end else begin
        state_d = FILL;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  dsp_sat_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_ac (
    .clk       (clk),
    .rst       (rst),
    .en        (accept),
    .load      (load),
    .add       (ac_in),
    .acc_nxt_c (nxt_ac),
    .ovf_nxt_c (nov_ac)
  );

  dsp_sat_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_bc (
    .clk       (clk),
    .rst       (rst),
    .en        (accept),
    .load      (load),
    .add       (bc_in),
    .acc_nxt_c (nxt_bc),
    .ovf_nxt_c (nov_bc)
  );

  // Result register: a new completion wins over a drain in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_out <= 1'b0;
      sum_ac    <= '0;
      sum_bc    <= '0;
      ovf_ac    <= 1'b0;
      ovf_bc    <= 1'b0;
    end else if (accept && last) begin
      valid_out <= 1'b1;
      sum_ac    <= nxt_ac;
      sum_bc    <= nxt_bc;
      ovf_ac    <= nov_ac;
      ovf_bc    <= nov_bc;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: doc/dsp_dual_acc.md
Name: dsp_dual_acc

Overview:
- Consumer end of the `dsp_dual_mult` result interface.
- Accepts the paired signed products (`ac`, `bc`, qualified by valid) and accumulates LEN consecutive pairs per channel with saturation.
- Presents the two sums on a valid/ready output port.
- Sits between the packed dual multiplier and the next layer stage, e.g. a 3x3 kernel dot-product reducer.

Parameters:
- IN_W, 16: width of each signed input product.
- ACC_W, 24: width of each signed accumulator and output sum (ACC_W >= IN_W).
- LEN, 9: products per accumulation group (LEN >= 1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- clr  in  1  synchronous abandon of the current partial group.
- valid_in  in  1  ac_in/bc_in valid this cycle.
- ready_in  out  1  block can accept a beat this cycle.
- ac_in  in  IN_W  signed product, channel A.
- bc_in  in  IN_W  signed product, channel B.
- sum_ac  out  ACC_W  signed group sum, channel A.
- sum_bc  out  ACC_W  signed group sum, channel B.
- ovf_ac  out  1  channel A saturated at least once in this group.
- ovf_bc  out  1  channel B saturated at least once in this group.
- valid_out  out  1  result register holds an unconsumed result.
- ready_out  in  1  downstream accepts the result.

Behaviour:
- Reset (rst=0 at posedge): clears accumulators, beat counter, sticky flags and result register.
  - Outputs after reset: valid_out=0; sum_ac=sum_bc=0; ovf_ac=ovf_bc=0; ready_in=1.
  - A mid-group reset discards partial sums.
  - A mid-hold reset drops the pending result.
- Beat acceptance: a beat is accepted when valid_in && ready_in.
  - Inputs are sign-extended to ACC_W+1 bits and added to the accumulator.
  - The result saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - On saturation, that channel's sticky overflow flag is set.
- Beat counter: 0..LEN-1.
  - The first beat of a group loads the accumulator with sext(input) rather than adding to it.
  - Overflow flags clear at group start.
- Group completion, on the accepted beat with count==LEN-1:
  - The final saturated sums and flags load the result register next cycle, with valid_out=1. Latency is 1 cycle from the last beat.
  - The counter wraps to 0.
- Output handshake:
  - valid_out stays high, with sum/ovf stable, until the cycle where valid_out && ready_out.
  - Simultaneous drain and new completion in the same cycle: the new result loads and valid_out stays 1.
- Backpressure:
  - ready_in = !(count==LEN-1 && valid_out && !ready_out).
  - Only the completing beat stalls; beats 0..LEN-2 are always accepted.
  - ready_in does not depend on valid_in.
- Control FSM:
  - States: ACCUM when count==0; FILL when 0<count<LEN.
  - The result register is independent, with a single valid bit.
  - LEN==1: every accepted beat completes a group.
- clr:
  - Resets the counter and flags to group start.
  - Does not affect the result register.
  - A beat presented in the same cycle as clr is discarded.
  - rst has priority over clr.
- valid_in while ready_in=0: the beat is not consumed; the upstream holds it.

Decomposition:
- Package `dsp_pkg`:
  - Default widths IN_W/ACC_W.
  - `acc_t` typedef.
  - Function `sat_add(acc, sext_in)` returning the saturated sum plus an overflow bit.
- Sub-module `dsp_sat_acc`: one channel's accumulator and sticky flag, with inputs load/add/en. Instantiated twice.
- Top level holds the counter, ready logic and result register.

Test Plan:
1. LEN=4, ACC_W=24. Four beats: ac=100,200,300,-50 and bc=-1,-2,-3,-4, ready_out=1. Expected: valid_out one cycle after beat 4; sum_ac=550, sum_bc=-10; ovf_ac=ovf_bc=0.
2. LEN=2, ACC_W=16. Beats ac=30000,30000 and bc=-30000,-30000. Expected: sum_ac=32767, ovf_ac=1; sum_bc=-32768, ovf_bc=1. The next group, ac=1,2 and bc=1,2, yields 3/3 with both flags 0.
3. LEN=2, ready_out=0. Send 4 beats. Expected:
   - First result is held.
   - ready_in=0 on the 4th beat only.
   - Raising ready_out for 1 cycle drains the first result, then the second loads with no loss.
4. LEN=4. After 2 beats (ac=7,7), assert rst=0 for one cycle, then send 4 beats of ac=1. Expected: sum_ac=4, valid_out=0 during reset. Repeat using clr in place of rst: same sum_ac=4.
5. LEN=1. Continuous beats ac=-128,127,0 with ready_out=1. Expected: three consecutive results -128, 127, 0; valid_out held high throughout.
6. Randomized bench: random products, with a pipelined reference model (mirroring the `dsp_dual_mult` check style) comparing group sums and flags over 1000 groups. Expected: zero mismatches.
